// File: rtl/fruit_sprite_pkg.sv
// Shared types and constants for the fruit sprite arbiter.
// Object state, sprite geometry and screen limits.
package fruit_sprite_pkg;

  localparam int SPR_DIM = 60;
  localparam int D_W = $clog2(SPR_DIM);
  localparam logic [7:0] TRANSPARENT_IDX = 8'd0;
  localparam int SCREEN_W = 640;
  localparam int SCREEN_H = 480;

  typedef struct packed {
    logic       en;
    logic [9:0] x;
    logic [9:0] y;
  } obj_t;

endpackage

// File: rtl/fruit_sprite_arbiter_if.sv
// Object update port: valid/ready write of one object's
// position and enable into the shadow registers.
interface fruit_sprite_arbiter_if #(
  parameter int NUM_OBJ = 4
);
  localparam int ID_W = (NUM_OBJ > 1) ? $clog2(NUM_OBJ) : 1;

  logic            obj_wr_valid;
  logic            obj_wr_ready;
  logic [ID_W-1:0] obj_wr_id;
  logic [9:0]      obj_wr_x;
  logic [9:0]      obj_wr_y;
  logic            obj_wr_en;

  modport master (
    output obj_wr_valid,
    output obj_wr_id,
    output obj_wr_x,
    output obj_wr_y,
    output obj_wr_en,
    input  obj_wr_ready
  );

  modport slave (
    input  obj_wr_valid,
    input  obj_wr_id,
    input  obj_wr_x,
    input  obj_wr_y,
    input  obj_wr_en,
    output obj_wr_ready
  );
endinterface

// File: rtl/fruit_sprite_arbiter_sprite_hit_prio.sv
// Per-object hit test on the current pixel plus a fixed
// priority pick (lowest id wins) with the texel offset.
module sprite_hit_prio
  import fruit_sprite_pkg::*;
#(
  parameter int NUM_OBJ = 4,
  parameter int ID_W = 2
) (
  input  obj_t            act_i [NUM_OBJ],
  input  logic [9:0]      draw_x_i,
  input  logic [9:0]      draw_y_i,
  output logic            any_hit_o,
  output logic [ID_W-1:0] win_o,
  output logic [D_W-1:0]  dx_o,
  output logic [D_W-1:0]  dy_o
);

  logic [NUM_OBJ-1:0] hit;
  logic [D_W-1:0]     dx_a [NUM_OBJ];
  logic [D_W-1:0]     dy_a [NUM_OBJ];

  for (genvar g = 0; g < NUM_OBJ; g++) begin : g_obj
    logic [10:0] x_end;
    logic [10:0] y_end;
    logic        in_x;
    logic        in_y;
    // 11-bit ends: sprites past the right/bottom edge clip, never wrap
    assign x_end = {1'b0, act_i[g].x} + 11'(SPR_DIM);
    assign y_end = {1'b0, act_i[g].y} + 11'(SPR_DIM);
    assign in_x = (draw_x_i >= act_i[g].x)
                & ({1'b0, draw_x_i} < x_end);
    assign in_y = (draw_y_i >= act_i[g].y)
                & ({1'b0, draw_y_i} < y_end);
    assign hit[g] = act_i[g].en & in_x & in_y;
    assign dx_a[g] = D_W'(draw_x_i - act_i[g].x);
    assign dy_a[g] = D_W'(draw_y_i - act_i[g].y);
  end

  // Walk from highest to lowest id so the lowest hit remains
  always_comb begin
    any_hit_o = |hit;
    win_o = '0;
    dx_o = '0;
    dy_o = '0;
    for (int i = NUM_OBJ - 1; i >= 0; i--) begin
      if (hit[i]) begin
        win_o = ID_W'(i);
        dx_o = dx_a[i];
        dy_o = dy_a[i];
      end
    end
  end

endmodule

// File: rtl/fruit_sprite_arbiter.sv
// Shares one sprite ROM among several fruit objects:
// shadow/active object regs, 2-stage pixel pipeline.
module fruit_sprite_arbiter
  import fruit_sprite_pkg::*;
#(
  parameter int NUM_OBJ = 4,
  parameter int ADDR_W = 12,
  parameter int IDX_W = 8,
  localparam int ID_W = (NUM_OBJ > 1) ? $clog2(NUM_OBJ) : 1
) (
  input  logic              vga_clk,
  input  logic              reset,
  input  logic [9:0]        DrawX,
  input  logic [9:0]        DrawY,
  input  logic              blank,
  input  logic              frame_start,
  fruit_sprite_arbiter_if.slave wr_if,
  output logic [ADDR_W-1:0] rom_address,
  input  logic [IDX_W-1:0]  rom_q,
  output logic              pix_valid,
  output logic [IDX_W-1:0]  pix_index,
  output logic [ID_W-1:0]   pix_obj_id
);

  obj_t shadow_q [NUM_OBJ];
  obj_t active_q [NUM_OBJ];

  logic wr_ready;
  logic wr_acc;
  obj_t wr_obj;

  // Writes stall only on reset and on the commit cycle
  assign wr_ready = ~reset & ~frame_start;
  assign wr_if.obj_wr_ready = wr_ready;
  assign wr_acc = wr_if.obj_wr_valid & wr_ready;
  assign wr_obj = '{en: wr_if.obj_wr_en,
                    x: wr_if.obj_wr_x,
                    y: wr_if.obj_wr_y};

  // Shadow takes writes; active copies shadow at frame start
  always_ff @(posedge vga_clk) begin
    if (reset) begin
      for (int i = 0; i < NUM_OBJ; i++) begin
        shadow_q[i] <= '0;
        active_q[i] <= '0;
      end
    end else begin
      for (int i = 0; i < NUM_OBJ; i++) begin
        if (wr_acc && wr_if.obj_wr_id == ID_W'(i))
          shadow_q[i] <= wr_obj;
        if (frame_start)
          active_q[i] <= shadow_q[i];
      end
    end
  end

  logic            any_hit;
  logic [ID_W-1:0] win;
  logic [D_W-1:0]  dx;
  logic [D_W-1:0]  dy;

  sprite_hit_prio #(
    .NUM_OBJ (NUM_OBJ),
    .ID_W    (ID_W)
  ) u_hit (
    .act_i     (active_q),
    .draw_x_i  (DrawX),
    .draw_y_i  (DrawY),
    .any_hit_o (any_hit),
    .win_o     (win),
    .dx_o      (dx),
    .dy_o      (dy)
  );

  logic [ADDR_W-1:0] addr_d;
  logic [ADDR_W-1:0] addr_q;
  logic              s1_hit_q;
  logic [ID_W-1:0]   s1_id_q;

  assign addr_d = ADDR_W'(dy) * ADDR_W'(SPR_DIM)
                + ADDR_W'(dx);

  // Stage 1: ROM address of the winner; held on no hit
  always_ff @(posedge vga_clk) begin
    if (reset) begin
      addr_q <= '0;
      s1_hit_q <= 1'b0;
      s1_id_q <= '0;
    end else begin
      if (any_hit)
        addr_q <= addr_d;
      s1_hit_q <= any_hit & blank;
      s1_id_q <= win;
    end
  end

  assign rom_address = addr_q;

  logic             pv_d;
  logic             pv_q;
  logic [IDX_W-1:0] pi_q;
  logic [ID_W-1:0]  po_q;

  assign pv_d = s1_hit_q
              & (rom_q != IDX_W'(TRANSPARENT_IDX));

  // Stage 2: transparency cut and tagging of the ROM index
  always_ff @(posedge vga_clk) begin
    if (reset) begin
      pv_q <= 1'b0;
      pi_q <= '0;
      po_q <= '0;
    end else begin
      pv_q <= pv_d;
      pi_q <= pv_d ? rom_q : '0;
      po_q <= pv_d ? s1_id_q : '0;
    end
  end

  assign pix_valid = pv_q;
  assign pix_index = pi_q;
  assign pix_obj_id = po_q;

endmodule

// File: tb/tb_fruit_sprite_arbiter.sv
// Bench for fruit_sprite_arbiter: directed scenarios and
// random traffic against a per-pixel behavioural model.
module tb_fruit_sprite_arbiter;

  localparam int N = 4;

  logic       clk = 1'b0;
  logic       reset = 1'b1;
  logic [9:0] DrawX = '0;
  logic [9:0] DrawY = '0;
  logic       blank = 1'b0;
  logic       frame_start = 1'b0;
  logic [11:0] rom_address;
  logic [7:0] rom_q = '0;
  logic       pix_valid;
  logic [7:0] pix_index;
  logic [1:0] pix_obj_id;

  fruit_sprite_arbiter_if #(.NUM_OBJ(N)) wr_if ();

  fruit_sprite_arbiter #(
    .NUM_OBJ (N),
    .ADDR_W  (12),
    .IDX_W   (8)
  ) dut (
    .vga_clk     (clk),
    .reset       (reset),
    .DrawX       (DrawX),
    .DrawY       (DrawY),
    .blank       (blank),
    .frame_start (frame_start),
    .wr_if       (wr_if.slave),
    .rom_address (rom_address),
    .rom_q       (rom_q),
    .pix_valid   (pix_valid),
    .pix_index   (pix_index),
    .pix_obj_id  (pix_obj_id)
  );

  always #5 clk = ~clk;

  logic [7:0] rom_mem [4096];

  // ROM reads on the falling edge
  always @(negedge clk) rom_q <= rom_mem[rom_address];

  int n_chk = 0;
  int n_fail = 0;

  task automatic chk(string nm, logic [31:0] act,
                     logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d at %0t",
               nm, act, exp, $time);
    end
  endtask

  // Behavioural model: objects as int arrays, each pixel
  // resolved to its final output, then delayed one extra edge.
  int a_en[N], a_x[N], a_y[N];
  int s_en[N], s_x[N], s_y[N];
  int m_addr;
  int exp_v, exp_i, exp_id;
  int pnd_v, pnd_i, pnd_id;
  bit chk_en = 0;

  always @(posedge clk) begin
    int w, a, px, py;
    if (reset) begin
      for (int i = 0; i < N; i++) begin
        a_en[i] = 0; a_x[i] = 0; a_y[i] = 0;
        s_en[i] = 0; s_x[i] = 0; s_y[i] = 0;
      end
      m_addr = 0;
      exp_v = 0; exp_i = 0; exp_id = 0;
      pnd_v = 0; pnd_i = 0; pnd_id = 0;
    end else begin
      px = int'(DrawX);
      py = int'(DrawY);
      w = -1;
      for (int i = 0; i < N; i++)
        if (w < 0 && a_en[i] != 0
            && px >= a_x[i] && px < a_x[i] + 60
            && py >= a_y[i] && py < a_y[i] + 60)
          w = i;
      exp_v = pnd_v; exp_i = pnd_i; exp_id = pnd_id;
      pnd_v = 0; pnd_i = 0; pnd_id = 0;
      if (w >= 0) begin
        a = (py - a_y[w]) * 60 + (px - a_x[w]);
        m_addr = a;
        if (blank && rom_mem[a] != 8'd0) begin
          pnd_v = 1;
          pnd_i = int'(rom_mem[a]);
          pnd_id = w;
        end
      end
      if (frame_start) begin
        for (int i = 0; i < N; i++) begin
          a_en[i] = s_en[i]; a_x[i] = s_x[i]; a_y[i] = s_y[i];
        end
      end else if (wr_if.obj_wr_valid) begin
        s_en[wr_if.obj_wr_id] = int'(wr_if.obj_wr_en);
        s_x[wr_if.obj_wr_id] = int'(wr_if.obj_wr_x);
        s_y[wr_if.obj_wr_id] = int'(wr_if.obj_wr_y);
      end
    end
    chk_en = 1;
  end

  // Every-cycle compare, away from the active edge
  always @(negedge clk) begin
    if (chk_en) begin
      chk("ready", 32'(wr_if.obj_wr_ready),
          32'(!reset && !frame_start));
      chk("rom_address", 32'(rom_address), 32'(m_addr));
      chk("pix_valid", 32'(pix_valid), 32'(exp_v));
      chk("pix_index", 32'(pix_index), 32'(exp_i));
      chk("pix_obj_id", 32'(pix_obj_id), 32'(exp_id));
    end
  end

  task automatic cyc();
    @(posedge clk);
    #2;
  endtask

  task automatic pix(int x, int y, bit b);
    DrawX = 10'(x);
    DrawY = 10'(y);
    blank = b;
  endtask

  task automatic wr(int id, int x, int y, bit en);
    wr_if.obj_wr_valid = 1'b1;
    wr_if.obj_wr_id = 2'(id);
    wr_if.obj_wr_x = 10'(x);
    wr_if.obj_wr_y = 10'(y);
    wr_if.obj_wr_en = en;
    cyc();
    wr_if.obj_wr_valid = 1'b0;
  endtask

  task automatic commit();
    frame_start = 1'b1;
    cyc();
    frame_start = 1'b0;
  endtask

  initial begin
    int seen;
    for (int i = 0; i < 4096; i++)
      rom_mem[i] = ($urandom_range(3) == 0)
                   ? 8'd0 : 8'($urandom_range(255, 1));
    rom_mem[1230] = 8'h2A;
    rom_mem[1779] = 8'h77;
    rom_mem[610] = 8'h33;
    rom_mem[305] = 8'h55;
    wr_if.obj_wr_valid = 1'b0;
    wr_if.obj_wr_id = '0;
    wr_if.obj_wr_x = '0;
    wr_if.obj_wr_y = '0;
    wr_if.obj_wr_en = 1'b0;

    repeat (3) cyc();
    chk("rst_addr", 32'(rom_address), 32'd0);
    chk("rst_pv", 32'(pix_valid), 32'd0);
    chk("rst_pidx", 32'(pix_index), 32'd0);
    reset = 1'b0;
    #1;
    chk("rdy_after_rst", 32'(wr_if.obj_wr_ready), 32'd1);

    // Sparse full-frame scan with nothing enabled
    seen = 0;
    for (int y = 0; y < 480; y += 16)
      for (int x = 0; x < 640; x++) begin
        pix(x, y, 1'b1);
        cyc();
        if (pix_valid) seen++;
      end
    chk("scan_addr", 32'(rom_address), 32'd0);
    chk("scan_hits", 32'(seen), 32'd0);

    // Single object
    wr(0, 100, 50, 1'b1);
    commit();
    pix(130, 70, 1'b1);
    cyc();
    chk("a_addr", 32'(rom_address), 32'd1230);
    pix(99, 70, 1'b1);
    cyc();
    chk("a_pv", 32'(pix_valid), 32'd1);
    chk("a_idx", 32'(pix_index), 32'h2A);
    chk("a_id", 32'(pix_obj_id), 32'd0);
    chk("a_hold", 32'(rom_address), 32'd1230);
    pix(160, 70, 1'b1);
    cyc();
    chk("a_left", 32'(pix_valid), 32'd0);
    cyc();
    chk("a_right", 32'(pix_valid), 32'd0);
    pix(130, 70, 1'b0);
    cyc();
    cyc();
    chk("a_blank", 32'(pix_valid), 32'd0);

    // Overlap: id1 beats id2
    wr(0, 100, 50, 1'b0);
    wr(1, 110, 60, 1'b1);
    wr(2, 110, 60, 1'b1);
    commit();
    pix(115, 65, 1'b1);
    cyc();
    chk("o_addr", 32'(rom_address), 32'd305);
    pix(0, 0, 1'b0);
    cyc();
    chk("o_pv", 32'(pix_valid), 32'd1);
    chk("o_id", 32'(pix_obj_id), 32'd1);
    chk("o_idx", 32'(pix_index), 32'h55);
    cyc();
    rom_mem[305] = 8'd0;
    pix(115, 65, 1'b1);
    cyc();
    pix(0, 0, 1'b0);
    cyc();
    chk("o_transp", 32'(pix_valid), 32'd0);

    // Edge clip at bottom-right, no wrap to (0,0)
    wr(3, 600, 450, 1'b1);
    pix(639, 479, 1'b1);
    cyc();
    cyc();
    chk("e_precommit", 32'(pix_valid), 32'd0);
    commit();
    pix(639, 479, 1'b1);
    cyc();
    chk("e_addr", 32'(rom_address), 32'd1779);
    pix(0, 0, 1'b1);
    cyc();
    chk("e_pv", 32'(pix_valid), 32'd1);
    chk("e_id", 32'(pix_obj_id), 32'd3);
    chk("e_idx", 32'(pix_index), 32'h77);
    cyc();
    chk("e_nowrap", 32'(pix_valid), 32'd0);
    chk("e_hold", 32'(rom_address), 32'd1779);

    // Write colliding with frame_start
    wr_if.obj_wr_valid = 1'b1;
    wr_if.obj_wr_id = 2'd0;
    wr_if.obj_wr_x = 10'd200;
    wr_if.obj_wr_y = 10'd200;
    wr_if.obj_wr_en = 1'b1;
    frame_start = 1'b1;
    #1;
    chk("f_rdy0", 32'(wr_if.obj_wr_ready), 32'd0);
    cyc();
    frame_start = 1'b0;
    #1;
    chk("f_rdy1", 32'(wr_if.obj_wr_ready), 32'd1);
    cyc();
    wr_if.obj_wr_valid = 1'b0;
    pix(210, 210, 1'b1);
    cyc();
    cyc();
    chk("f_notyet", 32'(pix_valid), 32'd0);
    commit();
    pix(210, 210, 1'b1);
    cyc();
    chk("f_addr", 32'(rom_address), 32'd610);
    cyc();
    chk("f_pv", 32'(pix_valid), 32'd1);
    chk("f_idx", 32'(pix_index), 32'h33);

    // Reset while a pixel is valid
    reset = 1'b1;
    cyc();
    chk("r_pv", 32'(pix_valid), 32'd0);
    chk("r_addr", 32'(rom_address), 32'd0);
    reset = 1'b0;
    cyc();
    cyc();
    chk("r_off", 32'(pix_valid), 32'd0);
    commit();
    cyc();
    cyc();
    chk("r_disabled", 32'(pix_valid), 32'd0);

    // Random traffic
    for (int c = 0; c < 6000; c++) begin
      int o;
      if ($urandom_range(1) == 0) begin
        o = int'($urandom_range(N - 1));
        pix(s_x[o] + int'($urandom_range(79)) - 10,
            s_y[o] + int'($urandom_range(79)) - 10,
            $urandom_range(9) != 0);
        if (DrawX > 10'd639) DrawX = 10'($urandom_range(639));
        if (DrawY > 10'd479) DrawY = 10'($urandom_range(479));
      end else begin
        pix(int'($urandom_range(639)),
            int'($urandom_range(479)),
            $urandom_range(9) != 0);
      end
      frame_start = ($urandom_range(39) == 0);
      reset = ($urandom_range(599) == 0);
      wr_if.obj_wr_valid = ($urandom_range(5) == 0);
      wr_if.obj_wr_id = 2'($urandom_range(N - 1));
      wr_if.obj_wr_x = 10'($urandom_range(639));
      wr_if.obj_wr_y = 10'($urandom_range(479));
      wr_if.obj_wr_en = ($urandom_range(3) != 0);
      cyc();
    end
    reset = 1'b0;
    frame_start = 1'b0;
    wr_if.obj_wr_valid = 1'b0;
    cyc();
    cyc();

    $display("End of test - %0d assertions evaluated, %0d failures",
             n_chk, n_fail);
    $finish;
  end

endmodule

// File: doc/fruit_sprite_arbiter.md
Name: fruit_sprite_arbiter

Overview:
- Shares one 60x60 fruit sprite ROM (8-bit palette index per texel) among NUM_OBJ on-screen fruit objects.
- Per pixel: decides which object covers (DrawX, DrawY), forms the ROM address, and aligns the returned index with a per-pixel valid/owner tag for the palette/compositor stage.
- Object positions are written through a valid/ready port into shadow registers and committed atomically at frame start, so no frame shows a half-updated object.

Parameters:
- NUM_OBJ, 4: number of fruit objects; ids 0..NUM_OBJ-1.
- SPR_DIM, 60: sprite width and height in pixels.
- ADDR_W, 12: ROM address width; must satisfy 2^ADDR_W >= SPR_DIM*SPR_DIM.
- IDX_W, 8: palette index width.
- TRANSPARENT_IDX, 0: palette index treated as transparent.

Ports:
- vga_clk  in  1  pixel clock; all state on the rising edge.
- reset  in  1  synchronous, active-high reset.
- DrawX  in  10  current pixel column.
- DrawY  in  10  current pixel row.
- blank  in  1  1 = active video (not blanked).
- frame_start  in  1  one-cycle pulse at frame start; commits the shadow registers.
- obj_wr_valid  in  1  object update request.
- obj_wr_ready  out  1  update accepted when valid && ready.
- obj_wr_id  in  $clog2(NUM_OBJ)  object being updated.
- obj_wr_x  in  10  sprite top-left column.
- obj_wr_y  in  10  sprite top-left row.
- obj_wr_en  in  1  object visible after commit.
- rom_address  out  ADDR_W  registered address to the sprite ROM.
- rom_q  in  IDX_W  ROM data; valid one rising edge after rom_address changes (the ROM reads on the falling edge).
- pix_valid  out  1  opaque sprite pixel at the aligned position.
- pix_index  out  IDX_W  palette index; 0 when pix_valid = 0.
- pix_obj_id  out  $clog2(NUM_OBJ)  owning object; 0 when pix_valid = 0.

Behaviour:
- Reset: all shadow and active registers cleared (en = 0, x = y = 0); pipeline flags cleared; rom_address = 0, pix_valid = 0, pix_index = 0, pix_obj_id = 0; obj_wr_ready = 1 from the first cycle after reset deasserts.
- Update port:
  - obj_wr_ready = ~reset & ~frame_start; combinational, no other stall source.
  - An accepted write overwrites shadow[id] entirely. The last write before a commit wins.
  - A write and frame_start in the same cycle: the write is not accepted; the requester holds valid and it lands in the next cycle's shadow.
- Commit: on frame_start, active[i] <= shadow[i] for all i in one edge; the shadow is retained.
- Hit test (stage 0, combinational on the inputs):
  - Object i hits iff active[i].en, DrawX >= x, DrawX < x+SPR_DIM, DrawY >= y, DrawY < y+SPR_DIM.
  - Sums are computed at 11 bits, so sprites partly off the right/bottom edge clip cleanly with no wrap.
  - Priority: lowest hitting id wins (fixed priority).
- Stage 1 register:
  - rom_address <= (DrawY - y_w)*SPR_DIM + (DrawX - x_w) for the winner w; if no hit, rom_address holds its previous value.
  - s1_hit <= any_hit & blank; s1_id <= w.
- Stage 2 register:
  - pix_valid <= s1_hit & (rom_q != TRANSPARENT_IDX).
  - pix_index <= pix_valid-next ? rom_q : 0; pix_obj_id <= pix_valid-next ? s1_id : 0.
- Latency: outputs correspond to DrawX/DrawY/blank sampled exactly 2 rising edges earlier; fully pipelined, one pixel per clock.
- Transparency: a transparent texel of the winning object yields pix_valid = 0; lower-priority objects are not looked up (single ROM port).
- frame_start is ignored while reset is high.
- Reset asserted mid-line flushes both stages in the same edge; pix_valid = 0 on the next cycle.

Decomposition:
- Package fruit_sprite_pkg holds:
  - typedef obj_t {logic en; logic [9:0] x, y;}.
  - Constants SPR_DIM, TRANSPARENT_IDX, SCREEN_W = 640, SCREEN_H = 480.
- One sub-module, sprite_hit_prio: combinational hit test plus priority encoder over the active objects; outputs any_hit, winner id, dx, dy.

Test Plan:
- Reset, then scan a full frame with no writes: rom_address = 0, pix_valid = 0 throughout.
- Write id0 (x=100, y=50, en=1), pulse frame_start, drive (130, 70) with blank = 1: rom_address = 20*60+30 = 1230 after 1 edge; with rom_q = 0x2A, pix_valid = 1, pix_index = 0x2A, pix_obj_id = 0 after 2 edges. (99, 70) and (160, 70) give pix_valid = 0.
- Overlap: id1 at (110, 60) and id2 at (110, 60), both enabled: pixel (115, 65) gives pix_obj_id = 1 and rom_address = 5*60+5 = 305. With rom_q = TRANSPARENT_IDX, pix_valid = 0.
- Write id3 (x=600, y=450) without frame_start: no hits. After frame_start: (639, 479) hits with address 29*60+39 = 1779; no wrap hit at (0, 0).
- Write id0 in the frame_start cycle with valid held: obj_wr_ready = 0 that cycle, accept on the next cycle; the new position shows only after the following frame_start.
- Reset asserted while pix_valid = 1: pix_valid = 0 on the next cycle; all objects disabled after reset releases.
